// File: rtl/ama_riscv_lsu.sv
// ---------------------------------------------------------------------------
// ama_riscv_lsu
//   Load/store unit sitting after the ALU. Takes the ALU result as the
//   effective address, checks alignment/legality, drives a valid/ready
//   request to data memory, waits for load data and returns it aligned and
//   sign/zero-extended to writeback. Illegal accesses never reach memory and
//   are reported through err/err_addr. Only one op is in flight at a time.
//
// Parameters
//   TIMEOUT_CYCLES : RSP cycles without a response before the load is
//                    aborted with err (0 = wait forever)
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   req_valid/req_ready         execute-stage handshake
//   req_we, req_funct3          store/load, width and signedness
//   req_addr, req_wdata, req_rd effective address, store data, load dest
//   mem_req_valid/mem_req_ready memory request handshake
//   mem_addr, mem_we, mem_wstrb, mem_wdata   memory request fields
//   mem_rsp_valid, mem_rdata    load response
//   wb_valid, wb_rd, wb_data    load result pulse to writeback
//   st_done                     store accepted by memory (pulse)
//   err, err_addr               illegal access or load timeout (pulse)
//
// Every output is either a register or a decode of r_state, so no input
// reaches an output combinationally.
// ---------------------------------------------------------------------------
module ama_riscv_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,

    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
    output logic        err,
    output logic [31:0] err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1: the abort happens on the
    // edge that would take it to TIMEOUT_CYCLES.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);

    state_t             r_state;
    logic [31:0]        r_addr;
    logic [2:0]         r_funct3;
    logic               r_we;
    logic [4:0]         r_rd;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_illegal;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    assign req_ready     = (r_state == IDLE);
    assign mem_req_valid = (r_state == REQ);

    // Request legality and store lane placement, decoded from the request
    // inputs; only consumed when a request is accepted in IDLE.
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: w_illegal = 1'b0;
            3'b001, 3'b101: w_illegal = req_addr[0];
            3'b010:         w_illegal = (req_addr[1:0] != 2'b00);
            default:        w_illegal = 1'b1;
        endcase
        // Stores have no unsigned variants.
        if (req_we && req_funct3[2])
            w_illegal = 1'b1;

        case (req_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = 4'b0011 << req_addr[1:0];
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Load extraction uses the latched offset/width, so only the raw word
    // arrives combinationally and it goes straight into wb_data.
    always_comb begin
        w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load = {24'd0, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_funct3  <= '0;
            r_we      <= 1'b0;
            r_rd      <= '0;
            r_cnt     <= '0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            st_done   <= 1'b0;
            err       <= 1'b0;
            err_addr  <= '0;
        end else begin
            wb_valid <= 1'b0;
            st_done  <= 1'b0;
            err      <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        if (w_illegal) begin
                            err      <= 1'b1;
                            err_addr <= req_addr;
                        end else begin
                            r_addr    <= req_addr;
                            r_funct3  <= req_funct3;
                            r_we      <= req_we;
                            r_rd      <= req_rd;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_we    <= req_we;
                            // Loads carry no strobes.
                            mem_wstrb <= req_we ? w_wstrb : 4'b0000;
                            mem_wdata <= w_wdata;
                            r_state   <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (mem_req_ready) begin
                        if (r_we) begin
                            st_done <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= RSP;
                        end
                    end
                end

                RSP: begin
                    // A response in the final counted cycle still wins.
                    if (mem_rsp_valid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= r_rd;
                        wb_data  <= w_load;
                        r_state  <= IDLE;
                    end else if (TO_EN && (r_cnt == CNT_LAST)) begin
                        err      <= 1'b1;
                        err_addr <= r_addr;
                        r_state  <= IDLE;
                    end else if (TO_EN) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ama_riscv_lsu.sv
module tb_ama_riscv_lsu;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        st_done;
    logic        err;
    logic [31:0] err_addr;

    int checks = 0;
    int errors = 0;

    ama_riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done), .err(err), .err_addr(err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        int          n_wb;
        int          n_st;
        int          n_err;
        int          n_mreq;
        int          n_late;
        logic        ready0;
        logic        unstable;
        logic [31:0] wb_data;
        logic [4:0]  wb_rd;
        logic [31:0] err_addr;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } op_res_t;

    // Reference behaviour, written straight from the access-type table.
    function automatic logic ref_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000: return 1'b1;
            3'b001: return !a[0];
            3'b010: return a[1:0] == 2'b00;
            3'b100: return !we;
            3'b101: return !we && !a[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000: return (off == 2'd0) ? 4'b0001 : (off == 2'd1) ? 4'b0010 :
                           (off == 2'd2) ? 4'b0100 : 4'b1000;
            3'b001: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdat(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            3'b001: return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> (8 * off);
        case (f3)
            3'b000: return {{24{sh[7]}}, sh[7:0]};
            3'b100: return {24'd0, sh[7:0]};
            3'b001: return {{16{sh[15]}}, sh[15:0]};
            3'b101: return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Drives one request starting at the current (negedge) time, acts as the
    // memory with the given ready/response delays, and records what the DUT
    // produced until req_ready returns. Ends on a negedge, outputs sampled.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input int rdy_dly, input int rsp_dly, input logic [31:0] rdata,
                          input int idle_after, output op_res_t res);
        bit acc, in_rsp, done;
        int wt, rc;
        res = '0;
        acc = 0; in_rsp = 0; done = 0; wt = 0; rc = 0;
        res.ready0    = req_ready;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        req_rd     = rd;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            req_valid     = 1'b0;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_rdata     = 32'hDEAD_BEEF;
            res.cyc = res.cyc + 1;
            if (wb_valid) begin res.n_wb = res.n_wb + 1; res.wb_data = wb_data; res.wb_rd = wb_rd; end
            if (st_done) res.n_st = res.n_st + 1;
            if (err) begin res.n_err = res.n_err + 1; res.err_addr = err_addr; end
            if (mem_req_valid) begin
                if (res.n_mreq == 0) begin
                    res.maddr = mem_addr; res.mwe = mem_we;
                    res.wstrb = mem_wstrb; res.wdata = mem_wdata;
                end else if (mem_addr !== res.maddr || mem_we !== res.mwe ||
                             mem_wstrb !== res.wstrb || mem_wdata !== res.wdata) begin
                    res.unstable = 1'b1;
                end
                res.n_mreq = res.n_mreq + 1;
            end
            done = req_ready;
            if (!done) begin
                if (acc && !we) in_rsp = 1;
                if (in_rsp) begin
                    if (rc == rsp_dly) begin mem_rsp_valid = 1'b1; mem_rdata = rdata; end
                    rc++;
                end
                if (mem_req_valid) begin
                    if (wt >= rdy_dly) begin mem_req_ready = 1'b1; acc = 1; end
                    wt++;
                end
            end
        end
        if (!done) res.cyc = 999;
        for (int i = 0; i < idle_after; i++) begin
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b0;
            if (wb_valid || st_done || err || mem_req_valid) res.n_late = res.n_late + 1;
            // Stray response while idle must be ignored.
            if (i == 0 && !we) begin mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
            checks++;
            if ({mem_req_valid, mem_we, wb_valid, st_done, err} !== 5'b0) begin
                errors++; $display("FAIL reset_ctrl got %b exp 00000", {mem_req_valid, mem_we, wb_valid, st_done, err});
            end
            checks++;
            if ({mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_data, err_addr} !== '0) begin
                errors++; $display("FAIL reset_data got %h %h %h %h %h %h exp 0", mem_addr, mem_wstrb, mem_wdata, wb_rd, wb_data, err_addr);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_stall();
        op_res_t r;
        run_op(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 3, 0, 32'h0, 2, r);
        checks++; if (r.ready0 !== 1'b1) begin errors++; $display("FAIL sb_ready got %b exp 1", r.ready0); end
        checks++; if (r.maddr !== 32'h1000) begin errors++; $display("FAIL sb_addr got %h exp 00001000", r.maddr); end
        checks++; if (r.wstrb !== 4'b1000) begin errors++; $display("FAIL sb_strb got %b exp 1000", r.wstrb); end
        checks++; if (r.wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got %h exp a5a5a5a5", r.wdata); end
        checks++; if (r.mwe !== 1'b1) begin errors++; $display("FAIL sb_we got %b exp 1", r.mwe); end
        checks++; if (r.unstable !== 1'b0) begin errors++; $display("FAIL sb_stable got unstable exp stable"); end
        checks++; if (r.n_mreq != 4) begin errors++; $display("FAIL sb_mreq_cycles got %0d exp 4", r.n_mreq); end
        checks++; if (r.n_st != 1 || r.n_wb != 0 || r.n_err != 0) begin
            errors++; $display("FAIL sb_pulses got st%0d wb%0d err%0d exp st1", r.n_st, r.n_wb, r.n_err); end
        checks++; if (r.cyc != 5) begin errors++; $display("FAIL sb_latency got %0d exp 5", r.cyc); end
        checks++; if (r.n_late != 0) begin errors++; $display("FAIL sb_late got %0d exp 0", r.n_late); end

        run_op(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 5'd0, 0, 0, 32'h0, 0, r);
        checks++; if (r.wstrb !== 4'b1100 || r.wdata !== 32'hBEEF_BEEF || r.cyc != 2 || r.n_st != 1) begin
            errors++; $display("FAIL sh_lane got %b %h cyc%0d st%0d exp 1100 beefbeef cyc2 st1", r.wstrb, r.wdata, r.cyc, r.n_st); end
        run_op(1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 5'd0, 1, 0, 32'h0, 2, r);
        checks++; if (r.wstrb !== 4'b1111 || r.wdata !== 32'hCAFE_F00D || r.maddr !== 32'h1004 || r.cyc != 3) begin
            errors++; $display("FAIL sw_lane got %b %h %h cyc%0d exp 1111 cafef00d 00001004 cyc3", r.wstrb, r.wdata, r.maddr, r.cyc); end
    endtask

    task automatic test_loads();
        op_res_t r;
        logic [2:0]  f3;
        logic [31:0] a, rd_w, exp;
        logic [4:0]  rd;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: begin f3 = 3'b000; a = 32'h2002; rd_w = 32'h0080_0000; exp = 32'hFFFF_FF80; rd = 5'd5;  end
                1: begin f3 = 3'b100; a = 32'h2002; rd_w = 32'h0080_0000; exp = 32'h0000_0080; rd = 5'd6;  end
                2: begin f3 = 3'b001; a = 32'h2002; rd_w = 32'h8001_0000; exp = 32'hFFFF_8001; rd = 5'd7;  end
                3: begin f3 = 3'b101; a = 32'h2002; rd_w = 32'h8001_0000; exp = 32'h0000_8001; rd = 5'd31; end
                4: begin f3 = 3'b010; a = 32'h2004; rd_w = 32'h89AB_CDEF; exp = 32'h89AB_CDEF; rd = 5'd0;  end
                default: begin f3 = 3'b000; a = 32'h2001; rd_w = 32'h0000_7F00; exp = 32'h0000_007F; rd = 5'd1; end
            endcase
            run_op(1'b0, f3, a, 32'h0, rd, i % 2, i % 3, rd_w, 2, r);
            checks++; if (r.wb_data !== exp) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, r.wb_data, exp); end
            checks++; if (r.n_wb != 1 || r.n_err != 0 || r.n_st != 0 || r.wb_rd !== rd) begin
                errors++; $display("FAIL load%0d_wb got wb%0d err%0d rd%0d exp wb1 rd%0d", i, r.n_wb, r.n_err, r.wb_rd, rd); end
            checks++; if (r.cyc != 3 + (i % 2) + (i % 3) || r.mwe !== 1'b0 || r.maddr !== {a[31:2], 2'b00}) begin
                errors++; $display("FAIL load%0d_req got cyc%0d we%b addr %h exp cyc%0d", i, r.cyc, r.mwe, r.maddr, 3 + (i % 2) + (i % 3)); end
            checks++; if (r.n_late != 0) begin errors++; $display("FAIL load%0d_late got %0d exp 0", i, r.n_late); end
        end
    endtask

    task automatic test_illegal();
        op_res_t r;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin we = 1'b0; f3 = 3'b010; a = 32'h3002; end
                1: begin we = 1'b0; f3 = 3'b001; a = 32'h3001; end
                2: begin we = 1'b0; f3 = 3'b011; a = 32'h3000; end
                default: begin we = 1'b1; f3 = 3'b100; a = 32'h3010; end
            endcase
            run_op(we, f3, a, 32'hFFFF_FFFF, 5'd3, 0, 0, 32'h0, 2, r);
            checks++; if (r.n_err != 1 || r.err_addr !== a) begin
                errors++; $display("FAIL illegal%0d_err got n%0d addr %h exp n1 addr %h", i, r.n_err, r.err_addr, a); end
            checks++; if (r.n_mreq != 0 || r.n_wb != 0 || r.n_st != 0 || r.cyc != 1 || r.n_late != 0) begin
                errors++; $display("FAIL illegal%0d_side got mreq%0d wb%0d st%0d cyc%0d late%0d exp 0 0 0 1 0", i, r.n_mreq, r.n_wb, r.n_st, r.cyc, r.n_late); end
        end
    endtask

    task automatic test_timeout();
        op_res_t r;
        run_op(1'b0, 3'b010, 32'h4000, 32'h0, 5'd9, 0, 1000, 32'h0, 3, r);
        checks++; if (r.n_err != 1 || r.err_addr !== 32'h4000 || r.n_wb != 0) begin
            errors++; $display("FAIL timeout_err got err%0d addr %h wb%0d exp err1 addr 00004000 wb0", r.n_err, r.err_addr, r.n_wb); end
        checks++; if (r.cyc != 6) begin errors++; $display("FAIL timeout_latency got %0d exp 6", r.cyc); end
        checks++; if (r.n_late != 0) begin errors++; $display("FAIL timeout_late got %0d exp 0", r.n_late); end
        // Response in the last cycle before the abort still completes.
        run_op(1'b0, 3'b010, 32'h4004, 32'h0, 5'd9, 0, 3, 32'h5555_AAAA, 2, r);
        checks++; if (r.n_wb != 1 || r.n_err != 0 || r.wb_data !== 32'h5555_AAAA || r.cyc != 6) begin
            errors++; $display("FAIL timeout_edge got wb%0d err%0d data %h cyc%0d exp wb1 err0 5555aaaa cyc6", r.n_wb, r.n_err, r.wb_data, r.cyc); end
    endtask

    task automatic test_back_to_back();
        op_res_t r;
        run_op(1'b1, 3'b010, 32'h6000, 32'h1111_2222, 5'd0, 0, 0, 32'h0, 0, r);
        checks++; if (r.n_st != 1 || r.cyc != 2) begin errors++; $display("FAIL b2b_st got st%0d cyc%0d exp st1 cyc2", r.n_st, r.cyc); end
        run_op(1'b0, 3'b000, 32'h6003, 32'h0, 5'd4, 0, 0, 32'h8000_0000, 0, r);
        checks++; if (r.ready0 !== 1'b1 || r.n_wb != 1 || r.wb_data !== 32'hFFFF_FF80 || r.cyc != 3) begin
            errors++; $display("FAIL b2b_ld got rdy%b wb%0d data %h cyc%0d exp rdy1 wb1 ffffff80 cyc3", r.ready0, r.n_wb, r.wb_data, r.cyc); end
        run_op(1'b0, 3'b111, 32'h6008, 32'h0, 5'd4, 0, 0, 32'h0, 0, r);
        checks++; if (r.ready0 !== 1'b1 || r.n_err != 1 || r.err_addr !== 32'h6008 || r.cyc != 1) begin
            errors++; $display("FAIL b2b_err got rdy%b err%0d addr %h cyc%0d exp rdy1 err1 00006008 cyc1", r.ready0, r.n_err, r.err_addr, r.cyc); end
        run_op(1'b1, 3'b000, 32'h6001, 32'h0000_0042, 5'd0, 0, 0, 32'h0, 2, r);
        checks++; if (r.ready0 !== 1'b1 || r.n_st != 1 || r.wstrb !== 4'b0010 || r.wdata !== 32'h4242_4242) begin
            errors++; $display("FAIL b2b_sb got rdy%b st%0d %b %h exp rdy1 st1 0010 42424242", r.ready0, r.n_st, r.wstrb, r.wdata); end
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h5000; req_rd = 5'd2;
        @(negedge clk);
        req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++; if (req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_in_rsp got rdy%b mreq%b exp 0 0", req_ready, mem_req_valid); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b0 || err !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle got rdy%b wb%b err%b mreq%b exp 1 0 0 0", req_ready, wb_valid, err, mem_req_valid); end
        mem_rsp_valid = 1'b1; mem_rdata = 32'hAAAA_5555;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++; if (wb_valid !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
                errors++; $display("FAIL rstmid_late got wb%b err%b rdy%b exp 0 0 1", wb_valid, err, req_ready); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        op_res_t r;
        logic we, lg;
        logic [2:0] f3;
        logic [31:0] a, wd, rdat;
        logic [4:0] rd;
        int rdy, rsp, ecyc;
        for (int n = 0; n < 64; n++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            a    = $urandom;
            wd   = $urandom;
            rdat = $urandom;
            rd   = 5'($urandom_range(0, 31));
            rdy  = $urandom_range(0, 5);
            rsp  = $urandom_range(0, 5);
            lg   = ref_legal(we, f3, a);
            run_op(we, f3, a, wd, rd, rdy, rsp, rdat, 2 * $urandom_range(0, 1), r);
            checks++;
            if (r.n_wb + r.n_st + r.n_err != 1 || r.n_late != 0 || r.ready0 !== 1'b1) begin
                errors++; $display("FAIL rnd%0d_pulses got wb%0d st%0d err%0d late%0d rdy%b exp one", n, r.n_wb, r.n_st, r.n_err, r.n_late, r.ready0);
            end
            checks++;
            if (!lg) begin
                ecyc = 1;
                if (r.n_err != 1 || r.err_addr !== a || r.n_mreq != 0 || r.cyc != ecyc) begin
                    errors++; $display("FAIL rnd%0d_illegal got err%0d addr %h mreq%0d cyc%0d exp err addr %h", n, r.n_err, r.err_addr, r.n_mreq, r.cyc, a); end
            end else if (we) begin
                ecyc = 2 + rdy;
                if (r.n_st != 1 || r.maddr !== {a[31:2], 2'b00} || r.wstrb !== ref_strb(f3, a[1:0]) ||
                    r.wdata !== ref_wdat(f3, wd) || r.mwe !== 1'b1 || r.unstable || r.cyc != ecyc) begin
                    errors++; $display("FAIL rnd%0d_store got st%0d %h %b %h cyc%0d exp %b %h cyc%0d", n, r.n_st, r.maddr, r.wstrb, r.wdata, r.cyc, ref_strb(f3, a[1:0]), ref_wdat(f3, wd), ecyc); end
            end else if (rsp >= int'(TO)) begin
                ecyc = 2 + rdy + int'(TO);
                if (r.n_err != 1 || r.err_addr !== a || r.n_wb != 0 || r.cyc != ecyc) begin
                    errors++; $display("FAIL rnd%0d_timeout got err%0d addr %h cyc%0d exp err addr %h cyc%0d", n, r.n_err, r.err_addr, r.cyc, a, ecyc); end
            end else begin
                ecyc = 3 + rdy + rsp;
                if (r.n_wb != 1 || r.wb_data !== ref_load(f3, a[1:0], rdat) || r.wb_rd !== rd ||
                    r.maddr !== {a[31:2], 2'b00} || r.mwe !== 1'b0 || r.cyc != ecyc) begin
                    errors++; $display("FAIL rnd%0d_load got wb%0d %h rd%0d cyc%0d exp %h rd%0d cyc%0d", n, r.n_wb, r.wb_data, r.wb_rd, r.cyc, ref_load(f3, a[1:0], rdat), rd, ecyc); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        test_reset();
        test_store_stall();
        test_loads();
        test_illegal();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1);
    end

endmodule

// File: doc/ama_riscv_lsu.md
# ama_riscv_lsu

Load/store unit for the AMA-RISCV core, directly downstream of the ALU. It takes the ALU result (`out_s`) as the effective address, plus store data and access type, from the execute stage. It runs a valid/ready request and response handshake with data memory and returns aligned, sign- or zero-extended load data to writeback. Misaligned or invalid accesses are flagged and never reach memory.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles waiting for a load response before abort; 0 disables the timeout.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `req_valid`  in  1  execute stage presents a memory op.
- `req_ready`  out  1  LSU can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only).
- `req_addr`  in  32  effective address (ALU `out_s`).
- `req_wdata`  in  32  store data (rs2), LSB-justified.
- `req_rd`  in  5  load destination register.
- `mem_req_valid`  out  1  request to data memory.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  32  word-aligned address ({addr[31:2],2'b00}).
- `mem_we`  out  1  write enable.
- `mem_wstrb`  out  4  byte strobes.
- `mem_wdata`  out  32  store data, replicated into lanes.
- `mem_rsp_valid`  in  1  load data valid.
- `mem_rdata`  in  32  raw load word.
- `wb_valid`  out  1  one-cycle pulse: load result valid.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  extended load data.
- `st_done`  out  1  one-cycle pulse: store accepted by memory.
- `err`  out  1  one-cycle pulse: misaligned, invalid, or timeout.
- `err_addr`  out  32  offending `req_addr`.

## Operation
- FSM states: IDLE, REQ, RSP.
  - IDLE: `req_ready`=1. On `req_valid`, latch addr, wdata, funct3, we, rd.
    - Access legal: go to REQ.
    - Access illegal: pulse `err`, stay in IDLE.
  - REQ: `mem_req_valid`=1, with addr/we/wstrb/wdata held stable until `mem_req_ready`.
    - On acceptance, a store pulses `st_done` and goes to IDLE.
    - On acceptance, a load goes to RSP.
  - RSP: wait for `mem_rsp_valid`. Then register the extended data, pulse `wb_valid`, and go to IDLE.
- Illegal accesses:
  - H/HU with addr[0]=1.
  - W with addr[1:0]≠0.
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3[2]=1.
- Store lanes:
  - B: strobe = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - H: strobe = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - W: strobe = 1111, wdata unchanged.
- Load extract: select the byte/half at addr[1:0] from `mem_rdata`. B/H sign-extend; BU/HU zero-extend; W passes through.
- Timeout: a counter clears on entry to RSP and increments each RSP cycle without a response. When it reaches `TIMEOUT_CYCLES` (if nonzero): pulse `err` with the latched addr, no `wb_valid`, go to IDLE.
- `mem_rsp_valid` in IDLE or REQ is ignored.
- `wb_valid` fires even for rd=0; the register file discards it.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, timeout counter 0.
  - Outputs: `req_ready`=1 after reset; `mem_req_valid`, `mem_we`, `wb_valid`, `st_done`, `err`=0; `mem_addr`, `mem_wstrb`, `mem_wdata`, `wb_rd`, `wb_data`, `err_addr`=0.
- Reset mid-op (REQ/RSP): abort to IDLE, no pulse emitted. A late response is ignored.
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Request accepted at edge N:
  - `mem_req_valid` high from cycle N+1.
  - With `mem_req_ready`=1 at N+1, a store pulses `st_done` in cycle N+2, and `req_ready`=1 again in N+2.
  - Load best case: response at N+2, `wb_valid` in N+3, `req_ready` in N+3.
- Illegal request at edge N: `err` high for cycle N+1 only; `req_ready` stays 1.
- Back-to-back: the next request can be accepted in the same cycle that `wb_valid`, `st_done` or `err` is high.
- Throughput: one op in flight; `req_ready`=0 throughout REQ and RSP.

## Test plan
- Reset, then idle: all outputs zero except `req_ready`=1. Assert `rst_n`=0 mid-RSP: IDLE next cycle; late `mem_rsp_valid` produces no `wb_valid`.
- SB to 0x1003 with wdata 0xA5 → `mem_addr`=0x1000, `mem_wstrb`=1000, `mem_wdata`=0xA5A5A5A5. With `mem_req_ready` low for 3 cycles: fields stable, then one `st_done` pulse.
- LB from 0x2002 with `mem_rdata`=0x0080_0000 → `wb_data`=0xFFFFFF80. LBU at the same address → 0x00000080. LH at 0x2002 with `mem_rdata`=0x8001_0000 → 0xFFFF8001.
- LW at 0x3002, LH at 0x3001, funct3=011 → each gives one `err` pulse with correct `err_addr`, `mem_req_valid` never asserted.
- Load with no response, `TIMEOUT_CYCLES`=4 → `err` pulse 4 cycles after entering RSP, no `wb_valid`, returns to IDLE.
- 64 random legal/illegal ops with random memory ready/response delays (0–5 cycles), checked against a reference model → no mismatches, exactly one completion pulse per accepted op.
